// File: rtl/snn_input_loader.sv
// ---------------------------------------------------------------------------
// snn_input_loader
//
// Front end of the SNN digit classifier. UART bytes are unpacked LSB-first
// into the 1-bit input-unit RAM (NUM_PIXELS pixels). Once the last pixel is
// written the core gets a one-cycle start pulse and owns the RAM read address
// until it reports done. The classified digit is then latched for the
// LED/UART-TX stage.
//
// Optional feature: define SNN_LOADER_TIMEOUT_EN to abort a partial image
// after TIMEOUT_CYCLES idle cycles between bytes (err pulses, and the next
// byte becomes pixel byte 0). Without the macro err is tied to 0.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx_rdy       UART byte available (level, held until clr_rdy)
//   rx_data      received byte, valid while rx_rdy=1
//   clr_rdy      one-cycle pulse consuming the current UART byte
//   core_addr    RAM read address from the core (used while busy)
//   ram_addr     address to the input-unit RAM
//   ram_we       RAM write enable
//   ram_d        RAM write data (pixel bit)
//   start        one-cycle pulse launching the core
//   done         core completion pulse
//   digit        core result, valid with done
//   digit_out    latched classification result
//   result_vld   one-cycle pulse when digit_out updates
//   busy         high from start until done is received
//   err          one-cycle pulse on a timeout abort
// ---------------------------------------------------------------------------
module snn_input_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       clr_rdy,
    input  logic [9:0] core_addr,
    output logic [9:0] ram_addr,
    output logic       ram_we,
    output logic       ram_d,
    output logic       start,
    input  logic       done,
    input  logic [3:0] digit,
    output logic [3:0] digit_out,
    output logic       result_vld,
    output logic       busy,
    output logic       err
);

    localparam logic [9:0] LAST_ADDR = 10'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        S_WAIT_BYTE,
        S_UNPACK,
        S_START,
        S_BUSY
    } state_t;

    state_t     state, next_state;
    logic [9:0] wr_addr;
    logic [7:0] shift_reg;
    logic       last_write;
    logic       timeout_hit;

    // Image bytes always start on a multiple of 8, so the low three address
    // bits double as the bit-within-byte counter.

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT_BYTE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        next_state = state;
        clr_rdy    = 1'b0;
        ram_we     = 1'b0;
        ram_d      = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
        err        = 1'b0;
        last_write = 1'b0;

        unique case (state)
            S_WAIT_BYTE: begin
                if (rx_rdy) begin
                    // Gated by rst_n so a byte pending during reset is not
                    // consumed while the capture register is held cleared.
                    clr_rdy    = rst_n;
                    next_state = S_UNPACK;
                end else begin
                    err = timeout_hit;
                end
            end
            S_UNPACK: begin
                ram_we = 1'b1;
                ram_d  = shift_reg[0];
                if (wr_addr[2:0] == 3'd7) begin
                    if (wr_addr == LAST_ADDR) begin
                        last_write = 1'b1;
                        next_state = S_START;
                    end else begin
                        next_state = S_WAIT_BYTE;
                    end
                end
            end
            S_START: begin
                start      = 1'b1;
                next_state = S_BUSY;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (done) begin
                    next_state = S_WAIT_BYTE;
                end
            end
            default: next_state = S_WAIT_BYTE;
        endcase
    end

    // The core's read path is combinational: no added latency while busy.
    assign ram_addr = (state == S_BUSY) ? core_addr : wr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            shift_reg  <= '0;
            digit_out  <= '0;
            result_vld <= 1'b0;
        end else begin
            result_vld <= 1'b0;
            unique case (state)
                S_WAIT_BYTE: begin
                    if (rx_rdy) begin
                        shift_reg <= rx_data;
                    end else if (timeout_hit) begin
                        wr_addr <= '0;
                    end
                end
                S_UNPACK: begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    // Hold at the last pixel rather than stepping past the image.
                    if (!last_write) begin
                        wr_addr <= wr_addr + 10'd1;
                    end
                end
                S_START: begin
                    wr_addr <= '0;
                end
                S_BUSY: begin
                    if (done) begin
                        digit_out  <= digit;
                        result_vld <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SNN_LOADER_TIMEOUT_EN
    logic [20:0] idle_cnt;

    // Only a partially received image can time out; a byte arriving in the
    // same cycle as the limit takes priority over the abort.
    assign timeout_hit = (state == S_WAIT_BYTE) && (wr_addr != '0) &&
                         (idle_cnt == 21'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((state == S_WAIT_BYTE) && (wr_addr != '0) && !rx_rdy && !timeout_hit) begin
            idle_cnt <= idle_cnt + 21'd1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_snn_input_loader.sv
// ---------------------------------------------------------------------------
// tb_snn_input_loader
//
// Directed bench for snn_input_loader. A table of bytes with hand-computed
// pixel sequences covers the unpacking order; hand-written sequences cover
// the full image/start, busy back-pressure and done handling, reset in the
// middle of an image, and the idle timeout (active when SNN_LOADER_TIMEOUT_EN
// is defined, with TIMEOUT_CYCLES=100).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snn_input_loader;

    logic       clk;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rdy;
    logic [9:0] core_addr;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic       ram_d;
    logic       start;
    logic       done;
    logic [3:0] digit;
    logic [3:0] digit_out;
    logic       result_vld;
    logic       busy;
    logic       err;

    snn_input_loader #(
        .NUM_PIXELS     (784),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rdy    (clr_rdy),
        .core_addr  (core_addr),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_d      (ram_d),
        .start      (start),
        .done       (done),
        .digit      (digit),
        .digit_out  (digit_out),
        .result_vld (result_vld),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         cyc;
        logic [9:0] addr;
        logic       d;
    } wr_t;

    wr_t wq[$];
    int  cyc           = 0;
    int  clr_count     = 0;
    int  start_count   = 0;
    int  rv_count      = 0;
    int  err_count     = 0;
    int  last_clr_cyc  = -1;
    int  last_start_cyc = -1;
    int  last_rv_cyc   = -1;
    int  last_err_cyc  = -1;
    int  last_done_cyc = -1;

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ram_we) wq.push_back('{cyc, ram_addr, ram_d});
        if (clr_rdy)    begin clr_count++;   last_clr_cyc   = cyc; end
        if (start)      begin start_count++; last_start_cyc = cyc; end
        if (result_vld) begin rv_count++;    last_rv_cyc    = cyc; end
        if (err)        begin err_count++;   last_err_cyc   = cyc; end
        if (done)       last_done_cyc = cyc;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {11'd0, ram_addr, ram_we, ram_d, clr_rdy, start, busy,
                     result_vld, err, digit_out}, 32'd0);
    endtask

    // UART model: byte stays pending until a clr_rdy is seen, then drops.
    task automatic wait_consume();
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = clr_rdy;
        end
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        check("byte_consumed", 32'(got), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        wait_consume();
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wq.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic collect_byte(input string name, input logic [0:7] exp_d,
                                input int base, input int clr0);
        logic [0:7] got_d;
        logic [9:0] first_addr;
        int         lat;
        bit         contig;
        wait_writes(8, 20);
        check({name, "_nwrites"}, 32'(wq.size()), 32'd8);
        got_d      = '0;
        first_addr = '1;
        lat        = -1;
        contig     = 1'b0;
        if (wq.size() >= 8) begin
            contig     = 1'b1;
            first_addr = wq[0].addr;
            lat        = wq[0].cyc - last_clr_cyc;
            for (int k = 0; k < 8; k++) begin
                got_d[k] = wq[k].d;
                if (wq[k].addr != 10'(base + k) || wq[k].cyc != wq[0].cyc + k) contig = 1'b0;
            end
        end
        check({name, "_data"},    32'(got_d),            32'(exp_d));
        check({name, "_base"},    32'(first_addr),       32'(base));
        check({name, "_contig"},  32'(contig),           32'd1);
        check({name, "_clr_cnt"}, 32'(clr_count - clr0), 32'd1);
        check({name, "_latency"}, 32'(lat),              32'd1);
    endtask

    task automatic check_byte(input string name, input logic [7:0] b,
                              input logic [0:7] exp_d, input int base);
        int clr0;
        wq.delete();
        clr0 = clr_count;
        send_byte(b);
        collect_byte(name, exp_d, base, clr0);
    endtask

    // 98 bytes of 0xFF; the first may already be pending in the UART.
    task automatic full_image(input string name, input bit first_pending);
        int st0;
        bit ok;
        int start_lat;
        st0 = start_count;
        for (int i = 0; i < 98; i++) begin
            if (i == 97) check({name, "_no_early_start"}, 32'(start_count - st0), 32'd0);
            if (i == 0 && first_pending) wait_consume();
            else send_byte(8'hFF);
        end
        wait_writes(784, 20);
        for (int i = 0; i < 10 && start_count == st0; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_nwrites"}, 32'(wq.size()), 32'd784);
        ok = (wq.size() == 784);
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].addr != 10'(i) || wq[i].d !== 1'b1) ok = 1'b0;
        end
        check({name, "_order_data"}, 32'(ok), 32'd1);
        check({name, "_start_cnt"}, 32'(start_count - st0), 32'd1);
        start_lat = (wq.size() == 784) ? last_start_cyc - wq[783].cyc : -1;
        check({name, "_start_lat"}, 32'(start_lat), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd1);
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [7:0] rx;
        logic [0:7] exp_d;   // index k = pixel written at base+k
        int         base;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rv0;
        int clr0;
        int wr0;
        int err0;
        int last_wr;
        int img_bytes;

        vecs[0] = '{8'hA5, 8'b1010_0101,  0};
        vecs[1] = '{8'h01, 8'b1000_0000,  8};
        vecs[2] = '{8'h80, 8'b0000_0001, 16};
        vecs[3] = '{8'h3C, 8'b0011_1100, 24};
        vecs[4] = '{8'h0F, 8'b1111_0000, 32};
        vecs[5] = '{8'hF0, 8'b0000_1111, 40};

        rst_n     = 1'b0;
        rx_rdy    = 1'b0;
        rx_data   = 8'h00;
        core_addr = 10'h2AA;
        done      = 1'b0;
        digit     = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");

        // Unpack order and timing, one byte per table row
        for (int i = 0; i < 6; i++) begin
            check_byte($sformatf("vec%0d", i), vecs[i].rx, vecs[i].exp_d, vecs[i].base);
        end

        // Idle gap after a partial image
        last_wr = (wq.size() == 8) ? wq[7].cyc : 0;
        err0    = err_count;
        repeat (120) @(posedge clk);
        #1;
`ifdef SNN_LOADER_TIMEOUT_EN
        check("timeout_err_cnt", 32'(err_count - err0), 32'd1);
        check("timeout_err_cyc", 32'(last_err_cyc - last_wr), 32'd100);
        check_byte("after_timeout", 8'h55, 8'b1010_1010, 0);
        img_bytes = 1;
`else
        check("no_timeout_err", 32'(err_count - err0), 32'd0);
        check_byte("after_idle", 8'h55, 8'b1010_1010, 48);
        img_bytes = 7;
`endif

        // done outside BUSY is ignored
        rv0 = rv_count;
        @(posedge clk); #1;
        done  = 1'b1;
        digit = 4'd3;
        @(posedge clk); #1;
        done  = 1'b0;
        digit = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_done_digit", 32'(digit_out), 32'd0);
        check("idle_done_rv",    32'(rv_count - rv0), 32'd0);
        check("idle_done_busy",  32'(busy), 32'd0);

        // Clean restart, then a full image
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wq.delete();
        rst_n = 1'b1;
        full_image("img1", 1'b0);

        // BUSY: core owns the read address, UART is back-pressured
        core_addr = 10'h123;
        @(negedge clk);
        check("busy_ram_addr", 32'(ram_addr), 32'h123);
        @(posedge clk); #1;
        rx_data = 8'h55;
        rx_rdy  = 1'b1;
        clr0    = clr_count;
        wr0     = wq.size();
        repeat (5) @(posedge clk);
        #1;
        check("busy_no_clr",    32'(clr_count - clr0), 32'd0);
        check("busy_no_write",  32'(wq.size() - wr0), 32'd0);
        check("busy_held",      32'(busy), 32'd1);
        wq.delete();
        rv0   = rv_count;
        done  = 1'b1;
        digit = 4'd7;
        @(posedge clk); #1;
        done  = 1'b0;
        digit = 4'd0;
        wait_consume();
        check("done_rv_cnt",    32'(rv_count - rv0), 32'd1);
        check("done_rv_lat",    32'(last_rv_cyc - last_done_cyc), 32'd1);
        check("done_digit_out", 32'(digit_out), 32'd7);
        check("done_clr_lat",   32'(last_clr_cyc - last_done_cyc), 32'd1);
        check("done_busy_low",  32'(busy), 32'd0);
        collect_byte("pending_after_done", 8'b1010_1010, 0, clr0);
        img_bytes = 1;

        // Reset part way through the 41st byte with another byte pending
        for (int i = img_bytes; i < 40; i++) send_byte(8'h00);
        @(posedge clk); #1;
        rx_data = 8'hC3;
        rx_rdy  = 1'b1;
        wait_consume();
        repeat (2) @(posedge clk);
        #1;
        rx_data = 8'hFF;
        rx_rdy  = 1'b1;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("midop_reset_hold");
        @(posedge clk); #1;
        wq.delete();
        rst_n = 1'b1;
        full_image("img2", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 2ms", $time);
        $fatal(1);
    end

endmodule
